// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 128x32 data SRAM: core (c_*) and
// auxiliary master (x_*) share one access per cycle; read data returns the next cycle.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          mem_cen_n,
  output logic          mem_wen_n,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_oen_n,
  input  logic [DW-1:0] mem_q
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic           last;      // 1: aux held the most recent grant
  logic [WCW-1:0] wait_cnt;  // consecutive cycles aux was denied
  logic [AW-1:0]  a_hold;
  logic [DW-1:0]  d_hold;
  logic           c_win;     // tie-break result when both ports request

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    c_win = 1'b1;
    if (MODE == 0) c_win = last;
    else           c_win = (wait_cnt != WCW'(MAX_WAIT));
  end

  assign c_gnt   = ~rst & c_req & (~x_req | c_win);
  assign x_gnt   = ~rst & x_req & (~c_req | ~c_win);
  assign c_stall = c_req & ~c_gnt;

  // The SRAM latches on the falling edge, so address and data are driven straight from the winner.
  assign mem_cen_n = ~(c_gnt | x_gnt);
  assign mem_wen_n = ~((c_gnt & c_we) | (x_gnt & x_we));
  assign mem_a     = x_gnt ? x_addr  : (c_gnt ? c_addr  : a_hold);
  assign mem_d     = x_gnt ? x_wdata : (c_gnt ? c_wdata : d_hold);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      wait_cnt  <= '0;
      a_hold    <= '0;
      d_hold    <= '0;
      c_rvalid  <= 1'b0;
      x_rvalid  <= 1'b0;
      c_rdata   <= '0;
      x_rdata   <= '0;
      mem_oen_n <= 1'b1;
    end else begin
      mem_oen_n <= 1'b0;
      c_rvalid  <= c_gnt & ~c_we;
      x_rvalid  <= x_gnt & ~x_we;
      if (c_gnt && !c_we) c_rdata <= mem_q;
      if (x_gnt && !x_we) x_rdata <= mem_q;
      if (c_gnt || x_gnt) begin
        last   <= x_gnt;
        a_hold <= mem_a;
        d_hold <= mem_d;
      end
      if (x_req && !x_gnt) begin
        if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
